// File: rtl/fir_sample_serializer_if.sv
// ----------------------------------------------------------------------------
// fir_sample_serializer_if
// Sample handshake between the FIR output stage (source) and the serializer.
//
// Handshake: a sample transfers on a rising clk edge where s_tvalid and
// s_tready are both 1. The source raises s_tvalid independently of s_tready
// and holds s_tdata stable until the transfer completes. s_tready depends only
// on the sink's internal state and never on s_tvalid.
//
// Signals:
//   s_tdata  [DATA_W-1:0]  signed sample, source -> sink
//   s_tvalid               s_tdata valid,  source -> sink
//   s_tready               sink can accept, sink -> source
// ----------------------------------------------------------------------------
interface fir_sample_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;

    modport master (
        output s_tdata,
        output s_tvalid,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        output s_tready
    );
endinterface

// File: rtl/fir_sample_serializer.sv
// ----------------------------------------------------------------------------
// fir_sample_serializer
// Buffers signed FIR samples in a small FIFO and sends each one as a serial
// frame of DATA_W+2 cycles: start bit (1, ser_frame=1), DATA_W data bits MSB
// first, guard bit (0). Frames run back to back while the FIFO has data.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   s_axis      sample handshake (slave side of fir_sample_serializer_if)
//   ser_out     serial data line (registered)
//   ser_frame   high in the start cycle of each frame (registered)
//   busy        FSM not in IDLE (registered)
//   fifo_level  FIFO occupancy, 0..DEPTH
//   fsm_state   current FSM state, for observation
// ----------------------------------------------------------------------------
module fir_sample_serializer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    fir_sample_serializer_if.slave      s_axis,
    output logic                        ser_out,
    output logic                        ser_frame,
    output logic                        busy,
    output logic [LW-1:0]               fifo_level,
    output logic [1:0]                  fsm_state
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] GUARD = 2'd3;

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ser_out_q, ser_out_d;
    logic              ser_frame_q, ser_frame_d;
    logic              busy_q, busy_d;

    logic push;
    logic pop;
    logic not_empty;

    // Readiness depends only on occupancy, so a full FIFO simply stalls the
    // source; the sample stays on s_tdata until a slot frees up.
    assign s_axis.s_tready = (level_q != LW'(DEPTH));
    assign push            = s_axis.s_tvalid & s_axis.s_tready;
    // Uses the pre-edge level, so a sample written this edge is never popped
    // on the same edge.
    assign not_empty       = (level_q != '0);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // The MSB shown this cycle is consumed at the edge.
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                if (cnt_q == CW'(DATA_W - 1)) begin
                    state_d = GUARD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GUARD: begin
                // Chain straight into the next frame with no idle gap.
                if (not_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Outputs are decoded from the next state so the registered values match
    // the state present after each edge.
    always_comb begin
        ser_out_d   = 1'b0;
        ser_frame_d = 1'b0;
        busy_d      = (state_d != IDLE);
        case (state_d)
            START: begin
                ser_out_d   = 1'b1;
                ser_frame_d = 1'b1;
            end
            SHIFT:   ser_out_d = shreg_d[DATA_W-1];
            default: ser_out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_frame_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_frame_q <= ser_frame_d;
            busy_q      <= busy_d;
        end
    end

    // Storage needs no reset: reset clears the pointers and level, which
    // discards whatever the entries hold.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_axis.s_tdata;
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_frame  = ser_frame_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;
    assign fsm_state  = state_q;
endmodule

// File: doc/fir_sample_serializer.md
FIR_SAMPLE_SERIALIZER -- requirements
Module: fir_sample_serializer

Interface
REQ-001 Parameter: DATA_W, 8, width of signed sample accepted from the FIR output.
REQ-002 Parameter: DEPTH, 4, FIFO entries; power of two, minimum 2.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: s_tdata  input  DATA_W  signed sample from the FIR output stage.
REQ-006 Port: s_tvalid  input  1  s_tdata valid this cycle.
REQ-007 Port: s_tready  output  1  block can accept a sample this cycle.
REQ-008 Port: ser_out  output  1  serial data line.
REQ-009 Port: ser_frame  output  1  high during the start cycle of each frame.
REQ-010 Port: busy  output  1  FSM not in IDLE.
REQ-011 Port: fifo_level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-012 The block SHALL accept a sample on any rising edge where s_tvalid=1 and s_tready=1, and write it into the FIFO on that edge.
REQ-013 s_tready SHALL be combinational: s_tready = (fifo_level != DEPTH).
REQ-014 With s_tvalid=1 and the FIFO full, the block SHALL neither accept nor drop the sample; s_tdata is held by the source.
REQ-015 FIFO read and write pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-016 The FSM SHALL have states IDLE, START, SHIFT, GUARD.
REQ-017 IDLE: if fifo_level != 0, pop the head entry into a DATA_W shift register and go to START on the same edge; otherwise stay in IDLE.
REQ-018 START lasts exactly 1 cycle: ser_out=1, ser_frame=1; then go to SHIFT.
REQ-019 SHIFT lasts exactly DATA_W cycles: ser_out = current MSB of the shift register, shifted left once per cycle (MSB first, two's complement unchanged), ser_frame=0; then go to GUARD.
REQ-020 GUARD lasts exactly 1 cycle: ser_out=0, ser_frame=0; then go to START directly if the FIFO is non-empty (popping on that edge), else go to IDLE.
REQ-021 Frame length SHALL be DATA_W+2 cycles; back-to-back frames SHALL have no idle cycle between GUARD and the next START.
REQ-022 ser_out, ser_frame and busy SHALL be registered outputs, decoded from the state and shift register present after each edge.
REQ-023 In IDLE: ser_out=0, ser_frame=0, busy=0; busy=1 in START, SHIFT and GUARD.
REQ-024 Latency: for a sample pushed at edge k into an empty FIFO with the FSM in IDLE, ser_frame SHALL be 1 in the cycle following edge k+1.
REQ-025 A push and a pop at the same edge SHALL both take effect; a sample pushed into an empty FIFO SHALL NOT be popped on that same edge.
REQ-026 Assertion of s_tvalid SHALL be independent of s_tready; deassertion of s_tvalid mid-stream SHALL only stall pushes and never alter a frame in progress.

Reset
REQ-027 On reset=0, asynchronously: FSM=IDLE, pointers=0, fifo_level=0, shift register=0, ser_out=0, ser_frame=0, busy=0.
REQ-028 A reset asserted mid-frame SHALL abort the frame and discard all FIFO contents; no partial frame resumes after release.
REQ-029 s_tready SHALL read 1 during and immediately after reset, because the FIFO is empty.
REQ-030 The first push SHALL be possible on the first rising edge with reset=1.

Verification
REQ-031 Push single sample 8'sh A5 into idle block -> frame bits 1,1,0,1,0,0,1,0,1,0; ser_frame high only in the first of these cycles; busy high for 10 cycles.
REQ-032 Push 8'sh 7F, 8'sh 80, 8'sh FF on consecutive edges -> three contiguous 10-cycle frames in order; fifo_level peaks at 2; busy stays high for 30 cycles.
REQ-033 Hold s_tvalid=1 for 20 cycles with incrementing data -> s_tready drops when fifo_level=4, then one push occurs per pop; no sample is lost or duplicated; the output order matches the input order.
REQ-034 Assert reset in the 5th SHIFT cycle with 3 samples queued -> all outputs are 0 and fifo_level=0 immediately; after release, no frame appears until a new push.
REQ-035 Pop and push on the same edge with fifo_level=2 -> fifo_level stays 2; the pointer wrap across entry DEPTH-1 to 0 yields the correct data.
REQ-036 Push 8'sh 00 -> frame 1,0,0,0,0,0,0,0,0,0; ser_frame marks the start bit only.
